// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the two-port single-port-RAM arbiter: port identifiers and
// the per-cycle response record.
package sp_ram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  read;
    } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational from req and prio_q;
// prio_q flips to the loser only when both ports contend.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn_i,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output port_e      gnt_idx
);

    port_e prio_q;

    // Grant selection: a lone requester always wins, contention resolved by prio_q
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = PORT_A;
        if (!rstn_i) begin
            gnt     = 2'b00;
            gnt_idx = PORT_A;
        end else begin
            case (req)
                2'b01: begin
                    gnt     = 2'b01;
                    gnt_idx = PORT_A;
                end
                2'b10: begin
                    gnt     = 2'b10;
                    gnt_idx = PORT_B;
                end
                2'b11: begin
                    gnt     = (prio_q == PORT_A) ? 2'b01 : 2'b10;
                    gnt_idx = prio_q;
                end
                default: begin
                    gnt     = 2'b00;
                    gnt_idx = PORT_A;
                end
            endcase
        end
    end

    // Priority hand-over: the port that lost a contended cycle wins the next one
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            prio_q <= PORT_A;
        end else if (req == 2'b11) begin
            prio_q <= (prio_q == PORT_A) ? PORT_B : PORT_A;
        end else begin
            prio_q <= prio_q;
        end
    end

endmodule

// File: rtl/sp_ram_arb.sv
// Round-robin front end for a single-port RAM: muxes the granted port onto the
// RAM, routes the one-cycle-latency response back and holds each port's last read.
module sp_ram_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,

    input  logic                    a_req_i,
    output logic                    a_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic                    a_rvalid_o,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,

    input  logic                    b_req_i,
    output logic                    b_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic                    b_rvalid_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic [1:0]            gnt;
    port_e                 gnt_idx;
    resp_t                 resp_q;
    logic [DATA_WIDTH-1:0] a_hold_q;
    logic [DATA_WIDTH-1:0] b_hold_q;
    logic                  a_rd_resp;
    logic                  b_rd_resp;

    rr_arb2 u_arb (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .req     ({b_req_i, a_req_i}),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign a_gnt_o  = gnt[0];
    assign b_gnt_o  = gnt[1];
    assign ram_en_o = a_gnt_o | b_gnt_o;

    // Payload mux from the granted port; idle RAM bus is forced to zero
    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (a_gnt_o) begin
            ram_addr_o  = a_addr_i;
            ram_we_o    = a_we_i;
            ram_be_o    = a_be_i;
            ram_wdata_o = a_wdata_i;
        end else if (b_gnt_o) begin
            ram_addr_o  = b_addr_i;
            ram_we_o    = b_we_i;
            ram_be_o    = b_be_i;
            ram_wdata_o = b_wdata_i;
        end else begin
            ram_addr_o  = '0;
            ram_we_o    = 1'b0;
            ram_be_o    = '0;
            ram_wdata_o = '0;
        end
    end

    // Responses are gated by rstn_i so a grant just before reset never completes
    assign a_rvalid_o = rstn_i & resp_q.valid & (resp_q.port == PORT_A);
    assign b_rvalid_o = rstn_i & resp_q.valid & (resp_q.port == PORT_B);
    assign a_rd_resp  = a_rvalid_o & resp_q.read;
    assign b_rd_resp  = b_rvalid_o & resp_q.read;

    // Read data: live RAM data on a read response, otherwise the held value
    always_comb begin
        a_rdata_o = '0;
        b_rdata_o = '0;
        if (!rstn_i) begin
            a_rdata_o = '0;
            b_rdata_o = '0;
        end else begin
            a_rdata_o = a_rd_resp ? ram_rdata_i : a_hold_q;
            b_rdata_o = b_rd_resp ? ram_rdata_i : b_hold_q;
        end
    end

    // Response record captures this cycle's grant for next cycle's rvalid
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            resp_q <= '0;
        end else begin
            resp_q.valid <= ram_en_o;
            resp_q.port  <= gnt_idx;
            resp_q.read  <= ram_en_o & ~ram_we_o;
        end
    end

    // Hold registers track the last read data per port; writes leave them alone
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            if (a_rd_resp) a_hold_q <= ram_rdata_i;
            if (b_rd_resp) b_hold_q <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_sp_ram_arb.sv
// Directed scoreboard bench for sp_ram_arb with a behavioural one-cycle-latency RAM.
module tb_sp_ram_arb;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          a_req_i, a_gnt_o, a_we_i, a_rvalid_o;
    logic [AW-1:0] a_addr_i;
    logic [BW-1:0] a_be_i;
    logic [DW-1:0] a_wdata_i, a_rdata_o;
    logic          b_req_i, b_gnt_o, b_we_i, b_rvalid_o;
    logic [AW-1:0] b_addr_i;
    logic [BW-1:0] b_be_i;
    logic [DW-1:0] b_wdata_i, b_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i = 32'h0;

    always #5 clk = ~clk;

    sp_ram_arb #(.RAM_SIZE(32768), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_addr_i(a_addr_i), .a_we_i(a_we_i),
        .a_be_i(a_be_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_addr_i(b_addr_i), .b_we_i(b_we_i),
        .b_be_i(b_be_i), .b_wdata_i(b_wdata_i), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          port_b;
        logic          read;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] exp_mem [256];
    logic          exp_prio_b;
    logic [DW-1:0] hold_a, hold_b;
    req_t          nop;

    // Behavioural single-port RAM, read data one cycle after enable
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int i = 0; i < BW; i++)
                    if (ram_be_o[i]) ram_mem[ram_addr_o[9:2]][8*i +: 8] <= ram_wdata_o[8*i +: 8];
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o[9:2]];
            end
        end
    end

    function automatic req_t rd(input logic [AW-1:0] addr);
        req_t r;
        r = '{req: 1'b1, we: 1'b0, addr: addr, be: 4'hF, wdata: 32'h0};
        return r;
    endfunction

    function automatic req_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [BW-1:0] be);
        req_t r;
        r = '{req: 1'b1, we: 1'b1, addr: addr, be: be, wdata: data};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check last cycle's response and this cycle's grant
    task automatic step(input logic rst, input req_t ra, input req_t rb);
        exp_t          e;
        logic          ga, gb, ev_a, ev_b;
        logic [DW-1:0] ed_a, ed_b;
        req_t          rg;
        logic [7:0]    idx;
        rstn_i = rst;
        a_req_i = ra.req; a_we_i = ra.we; a_addr_i = ra.addr; a_be_i = ra.be; a_wdata_i = ra.wdata;
        b_req_i = rb.req; b_we_i = rb.we; b_addr_i = rb.addr; b_be_i = rb.be; b_wdata_i = rb.wdata;
        @(negedge clk);
        ev_a = 1'b0; ev_b = 1'b0; ed_a = hold_a; ed_b = hold_b;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (rst) begin
                if (e.port_b) begin
                    ev_b = 1'b1;
                    if (e.read) begin ed_b = e.data; hold_b = e.data; end
                end else begin
                    ev_a = 1'b1;
                    if (e.read) begin ed_a = e.data; hold_a = e.data; end
                end
            end
        end
        if (!rst) begin ed_a = 32'h0; ed_b = 32'h0; end
        chk("a_rvalid", {31'b0, a_rvalid_o}, {31'b0, ev_a});
        chk("b_rvalid", {31'b0, b_rvalid_o}, {31'b0, ev_b});
        chk("a_rdata", a_rdata_o, ed_a);
        chk("b_rdata", b_rdata_o, ed_b);
        ga = 1'b0; gb = 1'b0;
        if (rst) begin
            if (ra.req && rb.req) begin
                ga = !exp_prio_b;
                gb = exp_prio_b;
                exp_prio_b = ga;
            end else begin
                ga = ra.req;
                gb = rb.req;
            end
        end
        chk("a_gnt", {31'b0, a_gnt_o}, {31'b0, ga});
        chk("b_gnt", {31'b0, b_gnt_o}, {31'b0, gb});
        chk("ram_en", {31'b0, ram_en_o}, {31'b0, ga | gb});
        rg = ga ? ra : (gb ? rb : nop);
        chk("ram_addr", {17'b0, ram_addr_o}, {17'b0, rg.addr});
        chk("ram_we", {31'b0, ram_we_o}, {31'b0, rg.we});
        chk("ram_be", {28'b0, ram_be_o}, {28'b0, rg.be});
        chk("ram_wdata", ram_wdata_o, rg.wdata);
        if (ga || gb) begin
            idx      = rg.addr[9:2];
            e.port_b = gb;
            e.read   = !rg.we;
            e.data   = exp_mem[idx];
            if (rg.we)
                for (int i = 0; i < BW; i++)
                    if (rg.be[i]) exp_mem[idx][8*i +: 8] = rg.wdata[8*i +: 8];
            sb.push_back(e);
        end
        if (!rst) begin
            sb.delete();
            exp_prio_b = 1'b0;
            hold_a = 32'h0;
            hold_b = 32'h0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        exp_prio_b = 1'b0;
        hold_a = 32'h0;
        hold_b = 32'h0;
        nop = '0;

        // Reset held for 3 cycles with both ports requesting
        for (int i = 0; i < 3; i++) step(1'b0, rd(15'h0), rd(15'h4));
        step(1'b1, rd(15'h0), rd(15'h4));
        step(1'b1, nop, rd(15'h4));

        // Single-port write then read, hold while idle
        step(1'b1, wr(15'h100, 32'hDEADBEEF, 4'hF), nop);
        step(1'b1, rd(15'h100), nop);
        step(1'b1, nop, nop);
        step(1'b1, nop, nop);
        chk("a_hold_idle", a_rdata_o, 32'hDEADBEEF);

        // Preload data for contention and byte-write tests
        step(1'b1, wr(15'h0, 32'hA0A0A0A0, 4'hF), nop);
        step(1'b1, wr(15'h4, 32'hB1B1B1B1, 4'hF), nop);
        step(1'b1, wr(15'h8, 32'hC2C2C2C2, 4'hF), nop);
        step(1'b1, wr(15'h24, 32'h55667788, 4'hF), wr(15'h20, 32'h11223344, 4'hF));
        step(1'b1, wr(15'h24, 32'h55667788, 4'hF), nop);
        step(1'b1, nop, wr(15'h28, 32'h99AABBCC, 4'hF));

        // Six cycles of continuous contention: A, B, A, B, A, B
        step(1'b1, rd(15'h0), rd(15'h20));
        step(1'b1, rd(15'h4), rd(15'h20));
        step(1'b1, rd(15'h4), rd(15'h24));
        step(1'b1, rd(15'h8), rd(15'h24));
        step(1'b1, rd(15'h8), rd(15'h28));
        step(1'b1, rd(15'h0), rd(15'h28));
        step(1'b1, rd(15'h0), nop);

        // Byte write over existing word
        step(1'b1, nop, wr(15'h20, 32'h000000AA, 4'h1));
        step(1'b1, nop, rd(15'h20));
        step(1'b1, nop, nop);
        chk("b_byte_write", b_rdata_o, 32'h112233AA);

        // Back-to-back reads with a write response in between
        step(1'b1, rd(15'h0), nop);
        step(1'b1, rd(15'h4), nop);
        step(1'b1, wr(15'h30, 32'h12345678, 4'hF), nop);
        step(1'b1, rd(15'h8), nop);
        step(1'b1, nop, nop);
        step(1'b1, nop, nop);
        chk("a_b2b_hold", a_rdata_o, 32'hC2C2C2C2);

        // Reset in the cycle after a B read grant
        step(1'b1, rd(15'h0), rd(15'h20));
        step(1'b1, nop, rd(15'h20));
        step(1'b0, nop, nop);
        step(1'b1, nop, nop);
        chk("b_rdata_after_reset", b_rdata_o, 32'h0);
        step(1'b1, rd(15'h4), rd(15'h8));
        step(1'b1, nop, rd(15'h8));
        step(1'b1, nop, nop);
        step(1'b1, nop, nop);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_ram_arb.md
# sp_ram_arb

Two-port round-robin arbiter placed directly upstream of the single-port data/instruction RAM wrapper. It accepts requests from two masters, for example the core LSU and the debug/AXI bridge. Each master uses a req/gnt/rvalid handshake. The block grants at most one request per cycle to the RAM and routes the one-cycle-latency read data back to the master that issued the request. It also holds each port's last read data stable until that port's next response.

## Interface
Parameters:
- RAM_SIZE, 32768, RAM size in bytes; must match the downstream RAM wrapper.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.

Ports. Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.

Per-port signals, for p = a and p = b:
- p_req_i  in  1  request valid.
- p_gnt_o  out  1  request accepted this cycle.
- p_addr_i  in  ADDR_WIDTH  byte address.
- p_we_i  in  1  1 = write.
- p_be_i  in  DATA_WIDTH/8  byte enables.
- p_wdata_i  in  DATA_WIDTH  write data.
- p_rvalid_o  out  1  response for the request granted in the previous cycle.
- p_rdata_o  out  DATA_WIDTH  read data.

RAM side:
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  byte address.
- ram_we_o  out  1  write.
- ram_be_o  out  DATA_WIDTH/8  byte enables.
- ram_wdata_o  out  DATA_WIDTH  write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.

## Operation
- **Grant (combinational):**
  - Only one requester: grant it.
  - Both requesting: grant the port selected by prio_q.
  - rstn_i low: p_gnt_o = 0 and ram_en_o = 0 regardless of requests.
- **RAM drive:**
  - ram_en_o = a_gnt_o | b_gnt_o.
  - addr, we, be and wdata are muxed from the granted port.
  - When no port is granted, these outputs are driven 0.
- **Priority state prio_q (A or B), reset to A:**
  - Updated only when both ports request in the same cycle.
  - It is then set to the port not granted in that cycle.
  - A single requester never changes prio_q.
- **Response tracking:** registered resp_port_q, resp_valid_q and resp_read_q capture the grant every cycle.
- **Response generation:**
  - p_rvalid_o = resp_valid_q & (resp_port_q == p).
  - Writes also get a one-cycle rvalid pulse.
- **Read data:**
  - A port with rvalid for a read passes ram_rdata_i straight through to p_rdata_o.
  - Otherwise p_rdata_o = p_hold_q.
  - p_hold_q captures ram_rdata_i at the end of every read-response cycle for that port.
  - Write responses leave p_hold_q unchanged.
- **Back-to-back requests:** fully pipelined. A grant in cycle N+1 overlaps the response to the grant in cycle N. Sustained throughput is 1 access per cycle.
- **Address range:** address bits are passed unmodified; the RAM uses only the word-address bits. No range or alignment checking.
- **Reset mid-operation:** a request granted in the cycle before rstn_i goes low gets no rvalid. The reset edge clears resp_valid_q, prio_q and both hold registers.

## Timing
- **Reset values:**
  - p_gnt_o = 0, p_rvalid_o = 0, p_rdata_o = 0.
  - ram_en_o = 0; ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o = 0.
  - prio_q = A.
- **Grant latency:** 0 cycles (same cycle as p_req_i).
- **Response latency:** exactly 1 cycle after grant.
- **Ungranted request:** a master holds p_req_i and its payload stable until granted. The arbiter keeps no request state for it.
- **Starvation bound:** under continuous contention, each port is granted at least every second cycle.
- **Registers:** only prio_q, resp_*_q and the hold registers. All outputs except p_rdata_o are combinational from inputs and these registers.

## Structure
- **Package sp_ram_arb_pkg:**
  - typedef enum logic {PORT_A, PORT_B} port_e, used for prio_q and resp_port_q.
  - Response-record struct: valid, port, read.
- **Sub-module rr_arb2:** the 2-input round-robin grant logic plus prio_q.
  - Inputs: clk, rstn_i, req[1:0].
  - Outputs: gnt[1:0] one-hot, gnt_idx.
- **Top level:** payload mux, response registers and hold registers.

## Test plan
- **Reset:** hold rstn_i low for 3 cycles with a_req_i = b_req_i = 1 -> no gnt, ram_en_o = 0, rdata 0; after release, first grant goes to A.
- **Single-port write then read:**
  - A writes 0xDEADBEEF to 0x100 with be = 0xF -> a_gnt_o in the same cycle, a_rvalid_o in the next.
  - A then reads 0x100 -> a_rvalid_o one cycle later with a_rdata_o = 0xDEADBEEF.
  - a_rdata_o stays 0xDEADBEEF while idle.
- **Contention:** both ports request reads continuously for 6 cycles -> grants go A, B, A, B, A, B; each rvalid goes to the correct port with the correct data.
- **Byte write:** B writes 0x000000AA with be = 0x1 over 0x11223344 at 0x20 -> a later read returns 0x112233AA.
- **Back-to-back pipelining:** A issues reads to 0x0, 0x4, 0x8 in consecutive cycles -> rvalid on 3 consecutive cycles with the data in order. A write response in between leaves the hold value unchanged.
- **Reset mid-operation:** assert rstn_i in the cycle after a B read grant -> no b_rvalid_o; b_rdata_o = 0; prio_q returns to A.
